updown_mod_counter: RTL

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 83 ++++++++
 1 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter over 0..limit with wrap or saturate behaviour at the bounds.
// Optional step prescaler compiled in with `define UPDOWN_MOD_COUNTER_PRESCALER_EN.
module updown_mod_counter #(
  parameter int NBITS    = 8,
  parameter int SATURATE = 0,
  parameter int PBITS    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  logic             up,
  input  logic [NBITS-1:0] din,
  input  logic [NBITS-1:0] limit,
`ifdef UPDOWN_MOD_COUNTER_PRESCALER_EN
  input  logic [PBITS-1:0] prescale,
`endif
  output logic [NBITS-1:0] dout,
  output logic             at_limit,
  output logic             at_zero,
  output logic             wrap_pulse
);

  logic             tick;
  logic [NBITS-1:0] next_cnt;
  logic             bound_hit;

`ifdef UPDOWN_MOD_COUNTER_PRESCALER_EN
  logic [PBITS-1:0] pcnt;

  assign tick = enable && (pcnt == prescale);

  // Any event that restarts the count also restarts the step phase.
  always_ff @(posedge clock) begin
    if (reset || clear || load) pcnt <= '0;
    else if (enable)            pcnt <= tick ? '0 : pcnt + 1'b1;
  end
`else
  assign tick = enable;
`endif

  // dout+1 is only taken when dout < limit, so it can never overflow.
  always_comb begin
    next_cnt  = dout;
    bound_hit = 1'b0;
    if (up) begin
      if (dout < limit) begin
        next_cnt = dout + 1'b1;
      end else begin
        bound_hit = 1'b1;
        // Out-of-range counts always fold back to zero, even when saturating.
        if ((dout > limit) || (SATURATE == 0)) next_cnt = '0;
      end
    end else begin
      if (dout != '0) begin
        next_cnt = dout - 1'b1;
      end else begin
        bound_hit = 1'b1;
        if (SATURATE == 0) next_cnt = limit;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      dout       <= '0;
      wrap_pulse <= 1'b0;
    end else if (load) begin
      dout       <= din;
      wrap_pulse <= 1'b0;
    end else if (tick) begin
      dout       <= next_cnt;
      wrap_pulse <= bound_hit;
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

  assign at_limit = (dout == limit);
  assign at_zero  = (dout == '0);

endmodule
